// File: rtl/am_modulator_if.sv
// rtl/am_modulator_if.sv - control, audio handshake and RF status signals of the AM modulator
interface am_modulator_if #(
    parameter int WIDTH   = 12,
    parameter int PHASE_W = 24
);
    logic               enable;
    logic [PHASE_W-1:0] phase_inc;
    logic [WIDTH-1:0]   audio_in;
    logic               audio_valid;
    logic               audio_ready;
    logic               rf_out;
    logic               busy;
    logic               underflow;

    modport master (
        output enable, phase_inc, audio_in, audio_valid,
        input  audio_ready, rf_out, busy, underflow
    );

    modport slave (
        input  enable, phase_inc, audio_in, audio_valid,
        output audio_ready, rf_out, busy, underflow
    );
endinterface

// File: rtl/am_modulator.sv
// rtl/am_modulator.sv - AM transmitter: soft-start envelope x NCO carrier -> 1-bit sigma-delta; AMMOD_SINE_LUT_EN selects a sine ROM carrier
module am_modulator #(
    parameter int WIDTH      = 12,
    parameter int PHASE_W    = 24,
    parameter int SAMPLE_DIV = 2048,
    parameter int RAMP_DIV   = 256
) (
    input logic         clk,
    input logic         rst_n,
    am_modulator_if.slave bus
);
    localparam int SC_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int RC_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int M_W   = WIDTH + 9;
    localparam int ACC_W = WIDTH + 10;
    localparam logic signed [ACC_W-1:0] FS = ACC_W'(2 ** (WIDTH + 7));

    typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;

    state_t                    state_q, state_d;
    logic [7:0]                gain_q, gain_d;
    logic [RC_W-1:0]           ramp_cnt_q, ramp_cnt_d;
    logic [SC_W-1:0]           samp_cnt_q, samp_cnt_d;
    logic [WIDTH-1:0]          buf_q, buf_d;
    logic                      full_q, full_d;
    logic [WIDTH-1:0]          active_q, active_d;
    logic                      underflow_q, underflow_d;
    logic                      enable_q;
    logic [PHASE_W-1:0]        phase_q, phase_d;
    logic [WIDTH-1:0]          env1_q, env1_d;
    logic signed [7:0]         c2_q, c2_d;
    logic [WIDTH-1:0]          envs2_q, envs2_d;
    logic signed [M_W-1:0]     m3_q, m3_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;

    logic                      busy_w;
    logic                      ramp_wrap;
    logic                      tick;
    logic                      audio_ready_w;
    logic                      accept;
    logic                      rf_w;
    logic signed [7:0]         carrier_w;
    logic [WIDTH+7:0]          env_prod;

    assign busy_w        = (state_q != IDLE);
    assign ramp_wrap     = (ramp_cnt_q == RC_W'(RAMP_DIV - 1));
    assign tick          = busy_w && (samp_cnt_q == SC_W'(SAMPLE_DIV - 1));
    assign audio_ready_w = busy_w && !full_q;
    assign accept        = bus.audio_valid && audio_ready_w;
    // The idle gate keeps the pin quiet even though acc=0 would read as a 1.
    assign rf_w          = busy_w && !acc_q[ACC_W-1];
    assign env_prod      = (WIDTH+8)'(env1_q) * (WIDTH+8)'(gain_q);

    assign bus.audio_ready = audio_ready_w;
    assign bus.rf_out      = rf_w;
    assign bus.busy        = busy_w;
    assign bus.underflow   = underflow_q;

`ifdef AMMOD_SINE_LUT_EN
    // Quarter-wave table, round(127*sin((i+0.5)*pi/128)); the half-step offset makes the fold symmetric.
    localparam logic [6:0] SINE_ROM [64] = '{
          2,   5,   8,  11,  14,  17,  20,  23,  26,  29,  32,  35,  38,  41,  44,  47,
         50,  53,  56,  58,  61,  64,  67,  69,  72,  74,  77,  79,  82,  84,  86,  89,
         91,  93,  95,  97,  99, 101, 103, 105, 106, 108, 110, 111, 113, 114, 115, 117,
        118, 119, 120, 121, 122, 123, 124, 124, 125, 125, 126, 126, 127, 127, 127, 127
    };
    logic [7:0] ph_top;
    logic [5:0] rom_idx;
    logic [6:0] rom_mag;

    // Fold the top phase byte onto the first quadrant and restore the sign.
    always_comb begin
        ph_top    = phase_q[PHASE_W-1 -: 8];
        rom_idx   = ph_top[6] ? ~ph_top[5:0] : ph_top[5:0];
        rom_mag   = SINE_ROM[rom_idx];
        carrier_w = ph_top[7] ? -$signed({1'b0, rom_mag}) : $signed({1'b0, rom_mag});
    end
`else
    assign carrier_w = phase_q[PHASE_W-1] ? -8'sd127 : 8'sd127;
`endif

    // Transmit FSM: ramp up, hold, ramp down; a reversal resumes from the current gain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (bus.enable) state_d = RAMP_UP;
            RAMP_UP:   if (!bus.enable) state_d = RAMP_DOWN;
                       else if (gain_q == 8'd255) state_d = RUN;
            RUN:       if (!bus.enable) state_d = RAMP_DOWN;
            RAMP_DOWN: if (bus.enable) state_d = RAMP_UP;
                       else if (gain_q == 8'd0) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Soft-start gain: one step per ramp period, saturating; the period restarts on every state change.
    always_comb begin
        gain_d     = gain_q;
        ramp_cnt_d = (state_d != state_q || ramp_wrap) ? '0 : ramp_cnt_q + 1'b1;
        if (ramp_wrap) begin
            if (state_q == RAMP_UP && gain_q != 8'd255) gain_d = gain_q + 8'd1;
            if (state_q == RAMP_DOWN && gain_q != 8'd0) gain_d = gain_q - 8'd1;
        end
    end

    // Sample period timer and one-entry buffer; a tick sees the buffer as it was before a same-cycle accept.
    always_comb begin
        samp_cnt_d  = '0;
        buf_d       = buf_q;
        full_d      = full_q;
        active_d    = active_q;
        underflow_d = underflow_q;
        if (!busy_w) begin
            full_d   = 1'b0;
            active_d = '0;
        end else begin
            samp_cnt_d = tick ? '0 : samp_cnt_q + 1'b1;
            if (tick && full_q) begin
                active_d = buf_q;
                full_d   = 1'b0;
            end
            if (accept) begin
                buf_d  = bus.audio_in;
                full_d = 1'b1;
            end
        end
        if (state_q == IDLE && bus.enable && !enable_q) underflow_d = 1'b0;
        if (tick && !full_q) underflow_d = 1'b1;
    end

    // Envelope x carrier pipeline feeding a first-order sigma-delta; everything parks at zero in IDLE.
    always_comb begin
        phase_d = '0;
        env1_d  = '0;
        c2_d    = '0;
        envs2_d = '0;
        m3_d    = '0;
        acc_d   = '0;
        if (busy_w) begin
            phase_d = phase_q + bus.phase_inc;
            env1_d  = {~active_q[WIDTH-1], active_q[WIDTH-2:0]};
            c2_d    = carrier_w;
            envs2_d = WIDTH'(env_prod >> 8);
            m3_d    = M_W'($signed({1'b0, envs2_q})) * M_W'(c2_q);
            acc_d   = acc_q + ACC_W'(m3_q) - (rf_w ? FS : -FS);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gain_q      <= '0;
            ramp_cnt_q  <= '0;
            samp_cnt_q  <= '0;
            buf_q       <= '0;
            full_q      <= 1'b0;
            active_q    <= '0;
            underflow_q <= 1'b0;
            enable_q    <= 1'b0;
            phase_q     <= '0;
            env1_q      <= '0;
            c2_q        <= '0;
            envs2_q     <= '0;
            m3_q        <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            gain_q      <= gain_d;
            ramp_cnt_q  <= ramp_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            buf_q       <= buf_d;
            full_q      <= full_d;
            active_q    <= active_d;
            underflow_q <= underflow_d;
            enable_q    <= bus.enable;
            phase_q     <= phase_d;
            env1_q      <= env1_d;
            c2_q        <= c2_d;
            envs2_q     <= envs2_d;
            m3_q        <= m3_d;
            acc_q       <= acc_d;
        end
    end
endmodule
